// File: rtl/vga_sync_gen.sv
// VGA timing generator driven by a pixel-rate clock enable derived from the system clock.
// Sync and video flags are registered from next-state counters so they align with pixel_x/pixel_y.
module vga_sync_gen #(
   parameter int unsigned DIV      = 4,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic       pix_tick,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       line_start,
   output logic       frame_start
);

   localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX  = PW'(DIV - 1);
   localparam logic [9:0]    H_MAX    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0]    V_MAX    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [9:0]    HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0]    HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]    VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]    VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [9:0]    H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0]    V_VIS    = 10'(V_ACTIVE);

   logic [PW-1:0] pre_q, pre_d;
   logic [9:0]    x_q, x_d;
   logic [9:0]    y_q, y_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          video_on_q, video_on_d;

   always_comb begin
      pix_tick    = en & (pre_q == PRE_MAX);
      line_start  = pix_tick & (x_q == H_MAX);
      frame_start = line_start & (y_q == V_MAX);

      pre_d = pre_q;
      x_d   = x_q;
      y_d   = y_q;
      if (en) begin
         pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
      end
      if (pix_tick) begin
         x_d = line_start ? '0 : x_q + 10'd1;
      end
      if (line_start) begin
         y_d = frame_start ? '0 : y_q + 10'd1;
      end

      // Decoding the next counter values keeps the flags in step with the counters.
      hsync_d    = ~((x_d >= HS_FIRST) && (x_d <= HS_LAST));
      vsync_d    = ~((y_d >= VS_FIRST) && (y_d <= VS_LAST));
      video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre_q      <= '0;
         x_q        <= '0;
         y_q        <= '0;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         video_on_q <= 1'b1;
      end else begin
         pre_q      <= pre_d;
         x_q        <= x_d;
         y_q        <= y_d;
         hsync_q    <= hsync_d;
         vsync_q    <= vsync_d;
         video_on_q <= video_on_d;
      end
   end

   assign pixel_x  = x_q;
   assign pixel_y  = y_q;
   assign hsync    = hsync_q;
   assign vsync    = vsync_q;
   assign video_on = video_on_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a DIV=4 and a DIV=1 instance with a reduced raster, checked every cycle
// against an arithmetic model built from the count of enabled clock edges since reset.
module tb_vga_sync_gen;

   localparam int unsigned HA = 20, HF = 3, HS = 4, HB = 5;
   localparam int unsigned VA = 6,  VF = 2, VS = 2, VB = 3;
   localparam int unsigned HT = HA + HF + HS + HB;
   localparam int unsigned VT = VA + VF + VS + VB;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic en_a = 1'b0, en_b = 1'b0;

   logic       tk_a, hs_a, vs_a, vo_a, ls_a, fs_a;
   logic [9:0] px_a, py_a;
   logic       tk_b, hs_b, vs_b, vo_b, ls_b, fs_b;
   logic [9:0] px_b, py_b;

   int unsigned checks = 0;
   int unsigned errors = 0;
   bit          chk_on = 1'b0;
   bit          steady = 1'b0;

   always #5 clk = ~clk;

   vga_sync_gen #(.DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u_a (
      .clk(clk), .rst(rst), .en(en_a), .pix_tick(tk_a), .hsync(hs_a), .vsync(vs_a),
      .video_on(vo_a), .pixel_x(px_a), .pixel_y(py_a), .line_start(ls_a), .frame_start(fs_a));

   vga_sync_gen #(.DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                  .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u_b (
      .clk(clk), .rst(rst), .en(en_b), .pix_tick(tk_b), .hsync(hs_b), .vsync(vs_b),
      .video_on(vo_b), .pixel_x(px_b), .pixel_y(py_b), .line_start(ls_b), .frame_start(fs_b));

   // Reference state: number of enabled clock edges since the last reset.
   int unsigned n_a = 0, n_b = 0;
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         n_a <= 0;
         n_b <= 0;
      end else begin
         if (en_a) n_a <= n_a + 1;
         if (en_b) n_b <= n_b + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_model(input string d, input int unsigned div, input int unsigned n,
                              input logic en, input logic tk, input logic hs, input logic vs,
                              input logic vo, input logic ls, input logic fs,
                              input logic [9:0] px, input logic [9:0] py);
      int unsigned pre, p, x, y;
      bit etk, els, efs;
      pre = n % div;
      p   = n / div;
      x   = p % HT;
      y   = (p / HT) % VT;
      etk = en && (pre == div - 1);
      els = etk && (x == HT - 1);
      efs = els && (y == VT - 1);
      check({d, ".pixel_x"},     32'(px), x);
      check({d, ".pixel_y"},     32'(py), y);
      check({d, ".pix_tick"},    32'(tk), 32'(etk));
      check({d, ".line_start"},  32'(ls), 32'(els));
      check({d, ".frame_start"}, 32'(fs), 32'(efs));
      check({d, ".hsync"},       32'(hs), 32'(!(x >= HA + HF && x <= HA + HF + HS - 1)));
      check({d, ".vsync"},       32'(vs), 32'(!(y >= VA + VF && y <= VA + VF + VS - 1)));
      check({d, ".video_on"},    32'(vo), 32'(x < HA && y < VA));
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         check_model("A", 4, n_a, en_a, tk_a, hs_a, vs_a, vo_a, ls_a, fs_a, px_a, py_a);
         check_model("B", 1, n_b, en_b, tk_b, hs_b, vs_b, vo_b, ls_b, fs_b, px_b, py_b);
      end
   end

   // Pulse widths and periods while both enables are held high.
   int unsigned cyc = 0;
   int unsigned hrun[2], vrun[2], last_ls[2], last_fs[2];
   bit          seen_ls[2], seen_fs[2];
   always @(negedge clk) begin
      logic hsv[2], vsv[2], lsv[2], fsv[2];
      int unsigned dv[2];
      hsv = '{hs_a, hs_b}; vsv = '{vs_a, vs_b};
      lsv = '{ls_a, ls_b}; fsv = '{fs_a, fs_b};
      dv  = '{4, 1};
      cyc++;
      if (!steady) begin
         for (int i = 0; i < 2; i++) begin
            hrun[i] = 0; vrun[i] = 0; seen_ls[i] = 0; seen_fs[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!hsv[i]) hrun[i]++;
            else if (hrun[i] != 0) begin
               check(i == 0 ? "A.hsync_width" : "B.hsync_width", hrun[i], HS * dv[i]);
               hrun[i] = 0;
            end
            if (!vsv[i]) vrun[i]++;
            else if (vrun[i] != 0) begin
               check(i == 0 ? "A.vsync_width" : "B.vsync_width", vrun[i], VS * HT * dv[i]);
               vrun[i] = 0;
            end
            if (lsv[i]) begin
               if (seen_ls[i])
                  check(i == 0 ? "A.line_period" : "B.line_period", cyc - last_ls[i], HT * dv[i]);
               seen_ls[i] = 1; last_ls[i] = cyc;
            end
            if (fsv[i]) begin
               if (seen_fs[i])
                  check(i == 0 ? "A.frame_period" : "B.frame_period", cyc - last_fs[i],
                        HT * VT * dv[i]);
               seen_fs[i] = 1; last_fs[i] = cyc;
            end
         end
      end
   end

   initial begin
      bit found;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk_on = 1'b1;
      @(negedge clk);
      #1;
      rst = 1'b0; en_a = 1'b1; en_b = 1'b1; steady = 1'b1;

      // First ticks after reset on the DIV=4 instance.
      repeat (3) @(posedge clk);
      #1 check("A.x_after3", 32'(px_a), 0);
      @(posedge clk);
      #1 check("A.x_after4", 32'(px_a), 1);
      repeat (4) @(posedge clk);
      #1 check("A.x_after8", 32'(px_a), 2);

      repeat (2 * HT * VT * 4 + 20) @(negedge clk);
      steady = 1'b0;

      // Enable gap at a known pixel with pre=2.
      found = 0;
      for (int i = 0; i < 4 * HT * 2 && !found; i++) begin
         @(negedge clk);
         if (n_a % 4 == 2 && (n_a / 4) % HT == 10) found = 1;
      end
      check("A.gate_wait_found", 32'(found), 1);
      #1 en_a = 1'b0;
      repeat (37) @(negedge clk);
      check("A.gate_hold_x", 32'(px_a), 10);
      check("A.gate_hold_tick", 32'(tk_a), 0);
      #1 en_a = 1'b1;
      @(negedge clk);
      check("A.resume_tick", 32'(tk_a), 1);
      check("A.resume_x_before", 32'(px_a), 10);
      @(negedge clk);
      check("A.resume_x_after", 32'(px_a), 11);

      // Random enables.
      repeat (3000) begin
         @(negedge clk);
         #1;
         en_a = ($urandom_range(0, 3) != 0);
         en_b = ($urandom_range(0, 7) != 0);
      end

      // Asynchronous reset while vsync is low on the last sync line.
      #1 en_a = 1'b1; en_b = 1'b1;
      found = 0;
      for (int i = 0; i < 2 * HT * VT * 4 && !found; i++) begin
         @(negedge clk);
         if ((n_a / 4 / HT) % VT == VA + VF + VS - 1) found = 1;
      end
      check("A.rst_wait_found", 32'(found), 1);
      check("A.vsync_before_rst", 32'(vs_a), 0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("A.rst_x", 32'(px_a), 0);
      check("A.rst_y", 32'(py_a), 0);
      check("A.rst_hsync", 32'(hs_a), 1);
      check("A.rst_vsync", 32'(vs_a), 1);
      check("A.rst_video_on", 32'(vo_a), 1);
      check("B.rst_x", 32'(px_b), 0);
      check("B.rst_y", 32'(py_b), 0);
      @(negedge clk);
      #1 rst = 1'b0;

      repeat (1000) begin
         @(negedge clk);
         #1;
         en_a = ($urandom_range(0, 7) != 0);
         en_b = ($urandom_range(0, 3) != 0);
      end

      @(negedge clk);
      chk_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
